pop_counter_bank: RTL

Parametrised bank of per-FIFO pop counters with a registered indexed readout port. Each channel counts pop strobes from one FIFO of the datapath; a host reads one channel per request through `req`/`idx`, optionally clearing it atomically. It succeeds the fixed five-channel combinational-readout counter block, adding configurable channel count and width, wrap/saturate modes, sticky overflow flags, clear-on-read and an invalid-index error.

---
 rtl/pop_counter_bank.sv | 88 ++++++++
 1 files changed

// File: rtl/pop_counter_bank.sv
// pop_counter_bank: per-channel pop counters with sticky overflow flags
// and a registered, indexed readout port with optional clear-on-read.
module pop_counter_bank #(
    parameter int NUM_CH   = 5,
    parameter int CNT_W    = 5,
    parameter int IDX_W    = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [NUM_CH-1:0] pop,
    input  logic              req,
    input  logic              clr,
    input  logic [IDX_W-1:0]  idx,
    output logic [CNT_W-1:0]  data,
    output logic              valid,
    output logic              err,
    output logic [NUM_CH-1:0] ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    rd_state_t         state;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [CNT_W-1:0]  rd_val;
    logic [NUM_CH-1:0] clr_hit;
    logic              idx_ok;

    // Decode the read select: range check, read mux and clear targets.
    always_comb begin
        idx_ok  = (int'(idx) < NUM_CH);
        rd_val  = '0;
        clr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx_ok && (int'(idx) == i)) begin
                rd_val     = cnt[i];
                clr_hit[i] = req && clr;
            end
        end
    end

    // Per-channel counters and sticky overflow; a clear beats an overflow.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_hit[i]) begin
                    cnt[i] <= {{(CNT_W-1){1'b0}}, pop[i]};
                    ovf[i] <= 1'b0;
                end else if (pop[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        ovf[i] <= 1'b1;
                        if (!SATURATE) begin
                            cnt[i] <= '0;
                        end
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Readout pipeline: one RESP cycle per sampled request, data/err registered.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            data  <= '0;
            err   <= 1'b0;
        end else begin
            state <= req ? RESP : IDLE;
            data  <= (req && idx_ok) ? rd_val : '0;
            err   <= req && !idx_ok;
        end
    end

    assign valid = (state == RESP);

endmodule
